// File: rtl/rhs_pkg.sv
// Shared types and sizing for the rhs_256 session sequencer.
package rhs_pkg;
  localparam int NUM_CHIPS         = 16;
  localparam int CHANNELS_PER_CHIP = 16;
  localparam int CH_W              = 12;
  localparam int SCALE_W           = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CFG_PULSE = 3'd1,
    S_CFG_WAIT  = 3'd2,
    S_REC       = 3'd3,
    S_ZC_PULSE  = 3'd4,
    S_ZC_WAIT   = 3'd5,
    S_ZC_NEXT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    P_IDLE, P_QUIET, P_SETUP, P_PULSE, P_ACK, P_BUSY
  } wait_phase_e;

  function automatic logic zc_range_ok(input logic [CH_W-1:0] first,
                                       input logic [CH_W-1:0] last,
                                       input int num_ch);
    return (first <= last) && ({{(32-CH_W){1'b0}}, last} < num_ch);
  endfunction
endpackage

// File: rtl/rhs_session_sequencer_if.sv
// Host request/status and rhs_256 control signals of the session sequencer.
interface rhs_session_sequencer_if;
  import rhs_pkg::*;
  logic               host_config_req;
  logic               host_record_req;
  logic               host_zcheck_req;
  logic [CH_W-1:0]    host_zc_first;
  logic [CH_W-1:0]    host_zc_last;
  logic [SCALE_W-1:0] host_zc_scale;
  logic               rhs_busy;
  logic               config_start;
  logic               record_start;
  logic               zcheck_start;
  logic [CH_W-1:0]    zcheck_global_channel;
  logic [SCALE_W-1:0] zcheck_scale;
  logic               configured;
  logic               zc_ch_done;
  logic               sweep_done;
  logic               req_error;
  logic [2:0]         state_dbg;

  modport master (
    output host_config_req, host_record_req, host_zcheck_req,
           host_zc_first, host_zc_last, host_zc_scale, rhs_busy,
    input  config_start, record_start, zcheck_start, zcheck_global_channel,
           zcheck_scale, configured, zc_ch_done, sweep_done, req_error, state_dbg
  );

  modport slave (
    input  host_config_req, host_record_req, host_zcheck_req,
           host_zc_first, host_zc_last, host_zc_scale, rhs_busy,
    output config_start, record_start, zcheck_start, zcheck_global_channel,
           zcheck_scale, configured, zc_ch_done, sweep_done, req_error, state_dbg
  );
endinterface

// File: rtl/rhs_busy_waiter.sv
// Start-pulse timer and rhs_busy handshake shared by config and zcheck; go -> start_pulse after one setup cycle
// (optionally preceded by a quiet gap). No backpressure: missing ack or stuck busy ends the operation via no_ack/timeout.
module rhs_busy_waiter
  import rhs_pkg::*;
#(
  parameter int START_PULSE_CYC = 16,
  parameter int BUSY_ACK_CYC    = 64,
  parameter int TIMEOUT_CYC     = 2**22
) (
  input  logic clk,
  input  logic rstn,
  input  logic go,
  input  logic quiet,
  input  logic rhs_busy,
  output logic start_pulse,
  output logic pulse_done,
  output logic done,
  output logic no_ack,
  output logic timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2*BUSY_ACK_CYC + START_PULSE_CYC + 1);

  wait_phase_e      phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    start_pulse = 1'b0;
    pulse_done  = 1'b0;
    done        = 1'b0;
    no_ack      = 1'b0;
    timeout     = 1'b0;
    case (phase_q)
      P_IDLE: if (go) begin
        phase_d = quiet ? P_QUIET : P_SETUP;
        cnt_d   = '0;
      end
      P_QUIET: if (cnt_q == CNT_W'(2*BUSY_ACK_CYC - 1)) begin
        phase_d = P_SETUP;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      P_SETUP: begin
        phase_d = P_PULSE;
        cnt_d   = '0;
      end
      P_PULSE: begin
        start_pulse = 1'b1;
        if (cnt_q == CNT_W'(START_PULSE_CYC - 1)) begin
          pulse_done = 1'b1;
          phase_d    = P_ACK;
          cnt_d      = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      P_ACK: if (rhs_busy) begin
        // The acknowledging cycle already counts towards the busy budget.
        phase_d = P_BUSY;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == CNT_W'(BUSY_ACK_CYC - 1)) begin
        no_ack  = 1'b1;
        phase_d = P_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      P_BUSY: if (!rhs_busy) begin
        done    = 1'b1;
        phase_d = P_IDLE;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
        timeout = 1'b1;
        phase_d = P_IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: phase_d = P_IDLE;
    endcase
  end
endmodule

// File: rtl/rhs_session_sequencer.sv
// Sequences config/record/zcheck-sweep operations of rhs_256; host request -> start pulse in 2 cycles, no queuing:
// conflicting or early requests raise req_error. RECORD_RESUME_EN lets a zcheck sweep interrupt and resume recording.
module rhs_session_sequencer
  import rhs_pkg::*;
#(
  parameter int NUM_CHANNELS    = 256,
  parameter int START_PULSE_CYC = 16,
  parameter int BUSY_ACK_CYC    = 64,
  parameter int TIMEOUT_CYC     = 2**22
) (
  input logic                    clk,
  input logic                    rstn,
  rhs_session_sequencer_if.slave bus
);
  state_e             state_q, state_d;
  logic [CH_W-1:0]    chan_q, chan_d, last_q, last_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic configured_q, configured_d, record_start_q, record_start_d;
  logic err_q, err_d, rec_req_prev_q, rec_req_prev_d;
  logic wait_go, wait_quiet, wait_start_pulse, wait_pulse_done, wait_done, wait_no_ack, wait_timeout;
  logic zc_ok;

  assign zc_ok = zc_range_ok(bus.host_zc_first, bus.host_zc_last, NUM_CHANNELS);

  rhs_busy_waiter #(
    .START_PULSE_CYC(START_PULSE_CYC), .BUSY_ACK_CYC(BUSY_ACK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_waiter (
    .clk(clk), .rstn(rstn), .go(wait_go), .quiet(wait_quiet), .rhs_busy(bus.rhs_busy),
    .start_pulse(wait_start_pulse), .pulse_done(wait_pulse_done), .done(wait_done),
    .no_ack(wait_no_ack), .timeout(wait_timeout)
  );

`ifdef RECORD_RESUME_EN
  logic resume_q, resume_d;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) resume_q <= 1'b0;
    else       resume_q <= resume_d;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      chan_q         <= '0;
      last_q         <= '0;
      scale_q        <= '0;
      configured_q   <= 1'b0;
      record_start_q <= 1'b0;
      err_q          <= 1'b0;
      rec_req_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      last_q         <= last_d;
      scale_q        <= scale_d;
      configured_q   <= configured_d;
      record_start_q <= record_start_d;
      err_q          <= err_d;
      rec_req_prev_q <= rec_req_prev_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    last_d         = last_q;
    scale_d        = scale_q;
    configured_d   = configured_q;
    record_start_d = 1'b0;
    rec_req_prev_d = bus.host_record_req;
    wait_go        = 1'b0;
    wait_quiet     = 1'b0;
    err_d          = (state_q != S_IDLE) && (state_q != S_REC) &&
                     (bus.host_config_req || bus.host_zcheck_req);
`ifdef RECORD_RESUME_EN
    resume_d       = resume_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.host_config_req) begin
          state_d = S_CFG_PULSE;
          wait_go = 1'b1;
        end else if (bus.host_zcheck_req) begin
          if (!configured_q || !zc_ok) err_d = 1'b1;
          else begin
            state_d = S_ZC_PULSE;
            wait_go = 1'b1;
            chan_d  = bus.host_zc_first;
            last_d  = bus.host_zc_last;
            scale_d = bus.host_zc_scale;
`ifdef RECORD_RESUME_EN
            resume_d = 1'b0;
`endif
          end
        end else if (bus.host_record_req) begin
          // Record is a level: flag the unconfigured case only on its rising edge.
          if (configured_q) state_d = S_REC;
          else if (!rec_req_prev_q) err_d = 1'b1;
        end
      end
      S_CFG_PULSE: if (wait_pulse_done) state_d = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (wait_done) begin
          state_d      = S_IDLE;
          configured_d = 1'b1;
        end else if (wait_no_ack || wait_timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          if (wait_timeout) configured_d = 1'b0;
        end
      end
      S_REC: begin
        record_start_d = bus.host_record_req;
        if (bus.host_config_req) err_d = 1'b1;
        if (!bus.host_record_req) begin
          state_d = S_IDLE;
          if (bus.host_zcheck_req) err_d = 1'b1;
        end else if (bus.host_zcheck_req) begin
`ifdef RECORD_RESUME_EN
          if (!zc_ok) err_d = 1'b1;
          else begin
            record_start_d = 1'b0;
            state_d        = S_ZC_PULSE;
            wait_go        = 1'b1;
            wait_quiet     = 1'b1;
            resume_d       = 1'b1;
            chan_d         = bus.host_zc_first;
            last_d         = bus.host_zc_last;
            scale_d        = bus.host_zc_scale;
          end
`else
          err_d = 1'b1;
`endif
        end
      end
      S_ZC_PULSE: if (wait_pulse_done) state_d = S_ZC_WAIT;
      S_ZC_WAIT: begin
        if (wait_done) state_d = S_ZC_NEXT;
        else if (wait_no_ack || wait_timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_ZC_NEXT: begin
        if (chan_q == last_q) begin
          state_d = S_IDLE;
`ifdef RECORD_RESUME_EN
          if (resume_q && bus.host_record_req) state_d = S_REC;
`endif
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = S_ZC_PULSE;
          wait_go = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.config_start          = (state_q == S_CFG_PULSE) && wait_start_pulse;
  assign bus.zcheck_start          = (state_q == S_ZC_PULSE) && wait_start_pulse;
  assign bus.record_start          = record_start_q;
  assign bus.zcheck_global_channel = chan_q;
  assign bus.zcheck_scale          = scale_q;
  assign bus.configured            = configured_q;
  assign bus.zc_ch_done            = (state_q == S_ZC_NEXT);
  assign bus.sweep_done            = (state_q == S_ZC_NEXT) && (chan_q == last_q);
  assign bus.req_error             = err_q;
  assign bus.state_dbg             = state_q;
endmodule

// File: tb/tb_rhs_session_sequencer.sv
// Directed bench for rhs_session_sequencer: zcheck range table plus hand sequences for config, record, errors, reset.
module tb_rhs_session_sequencer;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rhs_session_sequencer_if bus_if ();

  rhs_session_sequencer #(
    .NUM_CHANNELS(256), .START_PULSE_CYC(16), .BUSY_ACK_CYC(64), .TIMEOUT_CYC(1500)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus_if)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // rhs_busy model: 0 = answer each start pulse, 1 = never answer, 2 = stick high
  int busy_mode = 0;
  int busy_len  = 20;

  initial begin : responder
    logic prev;
    prev = 1'b0;
    bus_if.rhs_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev && !(bus_if.config_start || bus_if.zcheck_start) && busy_mode != 1) begin
        repeat (3) @(negedge clk);
        bus_if.rhs_busy = 1'b1;
        if (busy_mode == 2) wait (busy_mode != 2);
        else repeat (busy_len) @(negedge clk);
        @(negedge clk);
        bus_if.rhs_busy = 1'b0;
      end
      prev = bus_if.config_start || bus_if.zcheck_start;
    end
  end

  int cfg_cyc = 0, zc_rise = 0, done_cnt = 0, sweep_cnt = 0, err_cnt = 0;
  int ch_log[$];
  int sc_log[$];

  initial begin : monitor
    logic zs_prev;
    zs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.config_start) cfg_cyc++;
      if (bus_if.zcheck_start && !zs_prev) begin
        zc_rise++;
        ch_log.push_back(int'(bus_if.zcheck_global_channel));
        sc_log.push_back(int'(bus_if.zcheck_scale));
      end
      zs_prev = bus_if.zcheck_start;
      if (bus_if.zc_ch_done) done_cnt++;
      if (bus_if.sweep_done) sweep_cnt++;
      if (bus_if.req_error) err_cnt++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_cfg();
    bus_if.host_config_req = 1'b1;
    tick();
    bus_if.host_config_req = 1'b0;
  endtask

  task automatic pulse_zc(input logic [11:0] f, input logic [11:0] l, input logic [1:0] s);
    bus_if.host_zc_first   = f;
    bus_if.host_zc_last    = l;
    bus_if.host_zc_scale   = s;
    bus_if.host_zcheck_req = 1'b1;
    tick();
    bus_if.host_zcheck_req = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(bus_if.state_dbg) != s && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(bus_if.state_dbg), s);
  endtask

  typedef struct {
    logic [11:0] first;
    logic [11:0] last;
    logic [1:0]  scale;
    int          exp_err;
    int          exp_n;
    int          exp_sweep;
  } zc_vec_t;

  zc_vec_t vecs[6];

  initial begin : main
    int b_err, b_cfg, b_rise, b_done, b_sweep, b_log;
    vecs[0] = '{12'd12,  12'd15,  2'd3, 0, 4, 1};
    vecs[1] = '{12'd250, 12'd256, 2'd0, 1, 0, 0};
    vecs[2] = '{12'd5,   12'd4,   2'd1, 1, 0, 0};
    vecs[3] = '{12'd255, 12'd255, 2'd2, 0, 1, 1};
    vecs[4] = '{12'd0,   12'd2,   2'd1, 0, 3, 1};
    vecs[5] = '{12'd256, 12'd256, 2'd0, 1, 0, 0};

    rstn = 1'b0;
    bus_if.host_config_req = 1'b0;
    bus_if.host_record_req = 1'b0;
    bus_if.host_zcheck_req = 1'b0;
    bus_if.host_zc_first   = '0;
    bus_if.host_zc_last    = '0;
    bus_if.host_zc_scale   = '0;
    tick(3);
    check("rst_config_start", int'(bus_if.config_start), 0);
    check("rst_record_start", int'(bus_if.record_start), 0);
    check("rst_zcheck_start", int'(bus_if.zcheck_start), 0);
    check("rst_configured", int'(bus_if.configured), 0);
    check("rst_req_error", int'(bus_if.req_error), 0);
    check("rst_state", int'(bus_if.state_dbg), 0);
    check("rst_channel", int'(bus_if.zcheck_global_channel), 0);
    rstn = 1'b1;
    tick(2);

    // record before any configuration
    b_err = err_cnt;
    bus_if.host_record_req = 1'b1;
    tick(4);
    check("rec_unconf_err", err_cnt - b_err, 1);
    check("rec_unconf_start", int'(bus_if.record_start), 0);
    check("rec_unconf_state", int'(bus_if.state_dbg), 0);
    bus_if.host_record_req = 1'b0;
    tick(2);

    // configuration with a long busy phase
    busy_len = 1000;
    b_err = err_cnt; b_cfg = cfg_cyc;
    pulse_cfg();
    check("cfg_lat_c1", int'(bus_if.config_start), 0);
    tick();
    check("cfg_lat_c2", int'(bus_if.config_start), 1);
    wait_state(0, 1500, "cfg_idle");
    tick(2);
    check("cfg_pulse_cycles", cfg_cyc - b_cfg, 16);
    check("cfg_configured", int'(bus_if.configured), 1);
    check("cfg_err", err_cnt - b_err, 0);
    busy_len = 20;

    // busy never acknowledges
    busy_mode = 1;
    b_err = err_cnt;
    pulse_cfg();
    wait_state(0, 200, "noack_idle");
    tick(2);
    check("noack_err", err_cnt - b_err, 1);
    check("noack_configured", int'(bus_if.configured), 1);
    busy_mode = 0;
    tick(5);

    // recording
    bus_if.host_record_req = 1'b1;
    tick();
    check("rec_state", int'(bus_if.state_dbg), 3);
    check("rec_start_c1", int'(bus_if.record_start), 0);
    tick();
    check("rec_start_c2", int'(bus_if.record_start), 1);
    b_err = err_cnt;
    pulse_cfg();
    tick(2);
    check("rec_cfg_err", err_cnt - b_err, 1);
    check("rec_cfg_start", int'(bus_if.record_start), 1);

    b_err = err_cnt; b_rise = zc_rise; b_sweep = sweep_cnt;
    pulse_zc(12'd0, 12'd1, 2'd1);
`ifdef RECORD_RESUME_EN
    check("resume_rec_off", int'(bus_if.record_start), 0);
    wait_state(3, 1000, "resume_back_rec");
    tick(2);
    check("resume_rec_on", int'(bus_if.record_start), 1);
    check("resume_starts", zc_rise - b_rise, 2);
    check("resume_sweep", sweep_cnt - b_sweep, 1);
    check("resume_err", err_cnt - b_err, 0);
`else
    tick(2);
    check("rec_zc_err", err_cnt - b_err, 1);
    check("rec_zc_start", int'(bus_if.record_start), 1);
    check("rec_zc_state", int'(bus_if.state_dbg), 3);
    check("rec_zc_starts", zc_rise - b_rise, 0);
`endif
    bus_if.host_record_req = 1'b0;
    tick();
    check("rec_stop_start", int'(bus_if.record_start), 0);
    check("rec_stop_state", int'(bus_if.state_dbg), 0);
    tick(2);

    // zcheck range table
    for (int k = 0; k < 6; k++) begin
      b_err = err_cnt; b_rise = zc_rise; b_done = done_cnt; b_sweep = sweep_cnt; b_log = ch_log.size();
      pulse_zc(vecs[k].first, vecs[k].last, vecs[k].scale);
      wait_state(0, 600, "zc_idle");
      tick(2);
      check("zc_err", err_cnt - b_err, vecs[k].exp_err);
      check("zc_starts", zc_rise - b_rise, vecs[k].exp_n);
      check("zc_ch_done", done_cnt - b_done, vecs[k].exp_n);
      check("zc_sweep_done", sweep_cnt - b_sweep, vecs[k].exp_sweep);
      for (int j = 0; j < vecs[k].exp_n && (b_log + j) < ch_log.size(); j++) begin
        check("zc_channel", ch_log[b_log + j], int'(vecs[k].first) + j);
        check("zc_scale", sc_log[b_log + j], int'(vecs[k].scale));
      end
    end

    // busy stuck high
    busy_mode = 2;
    b_err = err_cnt;
    pulse_cfg();
    wait_state(0, 3000, "stuck_idle");
    tick(2);
    check("stuck_err", err_cnt - b_err, 1);
    check("stuck_configured", int'(bus_if.configured), 0);
    busy_mode = 0;
    tick(5);

    b_err = err_cnt; b_rise = zc_rise;
    pulse_zc(12'd0, 12'd0, 2'd0);
    tick(2);
    check("zc_unconf_err", err_cnt - b_err, 1);
    check("zc_unconf_starts", zc_rise - b_rise, 0);

    // simultaneous config and zcheck: config wins, zcheck dropped silently
    b_err = err_cnt; b_rise = zc_rise; b_cfg = cfg_cyc;
    bus_if.host_zc_first = 12'd0;
    bus_if.host_zc_last  = 12'd0;
    bus_if.host_config_req = 1'b1;
    bus_if.host_zcheck_req = 1'b1;
    tick();
    bus_if.host_config_req = 1'b0;
    bus_if.host_zcheck_req = 1'b0;
    wait_state(0, 300, "arb_idle");
    tick(2);
    check("arb_cfg_cycles", cfg_cyc - b_cfg, 16);
    check("arb_zc_starts", zc_rise - b_rise, 0);
    check("arb_err", err_cnt - b_err, 0);
    check("arb_configured", int'(bus_if.configured), 1);

    // request during a sweep, then reset mid-sweep
    pulse_zc(12'd0, 12'd3, 2'd2);
    for (int n = 0; n < 300 && !(bus_if.zcheck_start && bus_if.zcheck_global_channel == 12'd1); n++) tick();
    check("mid_channel", int'(bus_if.zcheck_global_channel), 1);
    b_err = err_cnt;
    pulse_cfg();
    tick(2);
    check("busy_req_err", err_cnt - b_err, 1);
    for (int n = 0; n < 300 && !bus_if.zcheck_start; n++) tick();
    check("pre_rst_zstart", int'(bus_if.zcheck_start), 1);
    #1 rstn = 1'b0;
    #1;
    check("arst_zcheck_start", int'(bus_if.zcheck_start), 0);
    check("arst_configured", int'(bus_if.configured), 0);
    check("arst_channel", int'(bus_if.zcheck_global_channel), 0);
    check("arst_scale", int'(bus_if.zcheck_scale), 0);
    check("arst_state", int'(bus_if.state_dbg), 0);
    tick(3);
    rstn = 1'b1;
    b_rise = zc_rise;
    tick(60);
    check("no_resume_starts", zc_rise - b_rise, 0);
    check("no_resume_state", int'(bus_if.state_dbg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
